// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - writeback request, register file write and scoreboard signals
interface rf_wb_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int RA_W    = 5
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*RA_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rf_we;
  logic [RA_W-1:0]         rf_a3;
  logic [XLEN-1:0]         rf_wd3;
  logic                    issue_valid;
  logic [RA_W-1:0]         issue_rd;
  logic                    issue_ready;
  logic [RA_W-1:0]         rs1;
  logic [RA_W-1:0]         rs2;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic [31:0]             pending;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
    input  req_ready, rf_we, rf_a3, rf_wd3, issue_ready, rs1_busy, rs2_busy, pending
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
    output req_ready, rf_we, rf_a3, rf_wd3, issue_ready, rs1_busy, rs2_busy, pending
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register file write port arbiter with pending-destination scoreboard
// Port 0 has absolute priority; ports 1..NUM_REQ-1 share the idle cycles round-robin.
module rf_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int RA_W    = 5
) (
  input logic              clk,
  input logic              reset,
  rf_wb_scheduler_if.slave bus
);
  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               ll_hs;
  logic               any_hs;
  logic [RA_W-1:0]    sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               rf_we_q;
  logic [RA_W-1:0]    rf_a3_q;
  logic [XLEN-1:0]    rf_wd3_q;
  logic [31:0]        pend;
  logic [31:0]        pend_next;
  logic               issue_fire;

  // Search order starts at ptr and wraps within 1..NUM_REQ-1, never touching port 0.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    ll_hs   = 1'b0;
    if (bus.req_valid[0]) begin
      gnt[0] = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ - 1; off++) begin
        idx = ((int'(ptr) - 1 + off) % (NUM_REQ - 1)) + 1;
        if (!ll_hs && bus.req_valid[idx]) begin
          ll_hs    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = PW'(idx);
        end
      end
    end
  end

  assign any_hs   = |(gnt & bus.req_valid);
  assign sel_rd   = bus.req_rd[gnt_idx*RA_W +: RA_W];
  assign sel_data = bus.req_data[gnt_idx*XLEN +: XLEN];

  assign bus.issue_ready = (bus.issue_rd == '0) || !pend[bus.issue_rd];
  assign issue_fire      = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

  // The clear comes first; a same-bit set cannot coincide because issue_ready is low then.
  always_comb begin
    pend_next = pend;
    if (ll_hs) begin
      pend_next[sel_rd] = 1'b0;
    end
    if (issue_fire) begin
      pend_next[bus.issue_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
      ptr      <= PW'(1);
      pend     <= '0;
    end else begin
      rf_we_q <= any_hs && (sel_rd != '0);
      if (any_hs) begin
        rf_a3_q  <= sel_rd;
        rf_wd3_q <= sel_data;
      end
      if (ll_hs) begin
        ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? PW'(1) : gnt_idx + PW'(1);
      end
      pend <= pend_next;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd3    = rf_wd3_q;
  assign bus.pending   = pend;
  assign bus.rs1_busy  = pend[bus.rs1];
  assign bus.rs2_busy  = pend[bus.rs2];
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  rf_wb_scheduler_if #(.NUM_REQ(3), .XLEN(32), .RA_W(5)) bus ();

  rf_wb_scheduler #(.NUM_REQ(3), .XLEN(32), .RA_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.req_valid[k]        = v;
    bus.req_rd[k*5 +: 5]    = rd;
    bus.req_data[k*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_rd      = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    step();
    step();
    check("rst_we", 32'(bus.rf_we), 32'd0);
    check("rst_a3", 32'(bus.rf_a3), 32'd0);
    check("rst_wd3", bus.rf_wd3, 32'd0);
    check("rst_pend", bus.pending, 32'd0);
    reset = 1'b0;

    // pipeline port write
    set_req(0, 1'b1, 5'd5, 32'hA5A5_0001);
    #1;
    check("p0_ready", 32'(bus.req_ready), 32'b001);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("p0_we", 32'(bus.rf_we), 32'd1);
    check("p0_a3", 32'(bus.rf_a3), 32'd5);
    check("p0_wd3", bus.rf_wd3, 32'hA5A5_0001);
    check("p0_pend", bus.pending, 32'd0);

    // scoreboard set, busy, clear by port 1
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    check("iss7_ready", 32'(bus.issue_ready), 32'd1);
    step();
    bus.issue_valid = 1'b0;
    bus.rs1         = 5'd7;
    bus.rs2         = 5'd6;
    #1;
    check("iss7_again", 32'(bus.issue_ready), 32'd0);
    check("pend7_set", bus.pending, 32'h0000_0080);
    check("rs1_busy7", 32'(bus.rs1_busy), 32'd1);
    check("rs2_busy6", 32'(bus.rs2_busy), 32'd0);
    set_req(1, 1'b1, 5'd7, 32'h0000_1234);
    #1;
    check("p1_ready", 32'(bus.req_ready), 32'b010);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("pend7_clr", bus.pending, 32'd0);
    check("rs1_free", 32'(bus.rs1_busy), 32'd0);
    check("p1_we", 32'(bus.rf_we), 32'd1);
    check("p1_a3", 32'(bus.rf_a3), 32'd7);
    check("p1_wd3", bus.rf_wd3, 32'h0000_1234);
    check("iss7_free", 32'(bus.issue_ready), 32'd1);

    // round robin between ports 1 and 2 from a fresh pointer
    do_reset();
    set_req(1, 1'b1, 5'd1, 32'h0000_0011);
    set_req(2, 1'b1, 5'd2, 32'h0000_0022);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'b010 : 32'b100);
      step();
      check("rr_we", 32'(bus.rf_we), 32'd1);
      check("rr_a3", 32'(bus.rf_a3), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // port 0 pre-empts both long-latency ports
    set_req(0, 1'b1, 5'd9, 32'h0000_0099);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pri_ready", 32'(bus.req_ready), 32'b001);
      step();
      check("pri_a3", 32'(bus.rf_a3), 32'd9);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("pri_after", 32'(bus.req_ready), 32'b010);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    check("pri_after_a3", 32'(bus.rf_a3), 32'd1);

    // rd=0 writes and issues are inert
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("rd0_ready", 32'(bus.req_ready), 32'b010);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("rd0_we", 32'(bus.rf_we), 32'd0);
    check("rd0_pend", bus.pending, 32'd0);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    #1;
    check("iss0_ready", 32'(bus.issue_ready), 32'd1);
    step();
    bus.issue_valid = 1'b0;
    check("iss0_pend", bus.pending, 32'd0);

    // reset right after a port 2 accept and a pending set
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    set_req(2, 1'b1, 5'd4, 32'h0000_0044);
    #1;
    check("t6_ready", 32'(bus.req_ready), 32'b100);
    step();
    bus.issue_valid = 1'b0;
    set_req(2, 1'b0, 5'd0, 32'h0);
    check("t6_pend3", bus.pending, 32'h0000_0008);
    check("t6_we_pre", 32'(bus.rf_we), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_we", 32'(bus.rf_we), 32'd0);
    check("t6_rst_pend", bus.pending, 32'd0);
    check("t6_rst_a3", 32'(bus.rf_a3), 32'd0);
    step();
    check("t6_no_write", 32'(bus.rf_we), 32'd0);
    reset = 1'b0;
    set_req(1, 1'b1, 5'd1, 32'h0000_0011);
    set_req(2, 1'b1, 5'd2, 32'h0000_0022);
    #1;
    check("t6_ptr", 32'(bus.req_ready), 32'b010);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    check("t6_post_a3", 32'(bus.rf_a3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
